output_port_qos_arbiter: RTL and testbench
==========================================

# output_port_qos_arbiter

Per-output-port switch arbiter for the NoC router. Each cycle it shares one output port among NUM_IN input ports using the decoded QoS value of each head flit. Highest QoS wins; ties break round-robin. It tracks downstream buffer credits and grants only when a credit is available. It sits between the input-port flit decoders and the crossbar select of one output port.

## Interface
Parameters:
- NUM_IN, 5: number of requesting input ports.
- QOS_W, 4: QoS value width; matches the decoded flit qos_value field.
- CREDIT_NUM, 4: downstream buffer depth, in flits.
- AGE_THRESH, 15: starvation threshold in cycles; used only with QOS_AGING_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_v_i  in  NUM_IN  per-input head-flit valid, targeting this output.
- req_qos_i  in  NUM_IN x QOS_W  per-input head-flit qos_value.
- credit_ret_i  in  1  one credit returned by the downstream buffer this cycle.
- gnt_o  out  NUM_IN  one-hot grant; the flit transfers when the grant bit is set.
- gnt_v_o  out  1  OR of gnt_o.
- gnt_idx_o  out  $clog2(NUM_IN)  binary index of the winner; 0 when gnt_v_o=0.
- credit_cnt_o  out  $clog2(CREDIT_NUM+1)  current credit count.
- credit_err_o  out  1  sticky flag set on credit overflow.

## Operation
- Eligible set: inputs with req_v_i=1. If credit_cnt=0, there is no grant and gnt_o=0.
- Winner selection:
  - Take the maximum req_qos_i among eligible inputs (unsigned).
  - Among inputs at that maximum, pick the first index >= rr_ptr, wrapping at NUM_IN.
- Exactly one grant per cycle at most. Each grant is a single-flit transfer; the input pops its flit on gnt_o.
- On a grant: rr_ptr <= (winner+1) mod NUM_IN. With no grant, rr_ptr holds.
- Credit counter:
  - Grant only: -1. Return only: +1. Both in the same cycle: unchanged.
  - Return while credit_cnt=CREDIT_NUM with no grant: the count holds and credit_err_o is set. It clears only on rst.
- Reset values: rr_ptr=0, credit_cnt=CREDIT_NUM, credit_err_o=0, all ages=0. Outputs are combinational from this state, so with no requests gnt_o=0, gnt_v_o=0 and gnt_idx_o=0.
- Reset mid-operation: in a cycle with rst=1, gnt_o is forced to 0. All state returns to its reset value on that edge.

## Timing
- Grant is combinational, zero-cycle: a request in cycle t is granted in cycle t if a credit is available.
- Credit and rr_ptr changes are visible from cycle t+1.
- A credit returned in cycle t is usable in cycle t+1, not in t.
- req_qos_i is sampled only while the matching req_v_i=1.
- Back-to-back grants to the same input are legal when it alone holds the top QoS.

## Configuration
- QOS_AGING_EN defined:
  - Each input holds an age counter, wide enough for AGE_THRESH.
  - The counter increments, saturating, every cycle the input is valid and not granted.
  - It resets to 0 when the input is granted or req_v_i=0.
  - An input with age >= AGE_THRESH is urgent. Urgent inputs beat all non-urgent inputs regardless of QoS.
  - Among urgent inputs, QoS is ignored and round-robin from rr_ptr applies.
  - A cycle with credit_cnt=0 does not age any input.
- QOS_AGING_EN undefined: no age registers. Strict QoS plus round-robin as above; starvation of low-QoS inputs is permitted.

## Structure
- Shared package noc_arb_pkg holds:
  - QOS_W
  - the default NUM_IN and CREDIT_NUM
  - the typedefs qos_t, port_idx_t and credit_cnt_t
- qos_t must match the qos_value field of the decoded-flit struct.
- One combinational sub-module, rr_pick, does the round-robin search.
  - Inputs: a NUM_IN request mask and a start pointer.
  - Outputs: a one-hot pick plus a found bit.
  - It is instantiated once for the QoS tier and once for the urgent tier (aging only).

## Test plan
- After reset, with req_v_i=0: gnt_o=0, credit_cnt_o=4, credit_err_o=0.
- All 5 inputs valid with qos=3, credit_ret_i pulsed each cycle: grants go 0,1,2,3,4,0 on consecutive cycles.
- Input 1 qos=2 and input 3 qos=7: input 3 is granted every cycle while credit lasts. With no returns, the 4 grants are followed by gnt_o=0 and credit_cnt_o=0.
- credit_cnt=0 with grant-eligible requests and credit_ret_i=1: no grant that cycle, one grant the next cycle.
- credit_ret_i=1 at credit_cnt=4 with no request: count stays 4 and credit_err_o=1 until rst. A grant together with a return keeps the count unchanged.
- With QOS_AGING_EN, AGE_THRESH=15, input 0 qos=0 and input 2 qos=15 both constantly valid, returns every cycle: input 0 is granted on the 16th cycle, then input 2 resumes.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared NoC arbitration types: QoS width, default port/credit sizing and the decoded head-flit header.
package noc_arb_pkg;

  localparam int unsigned QOS_W          = 4;
  localparam int unsigned NUM_IN_DEF     = 5;
  localparam int unsigned CREDIT_NUM_DEF = 4;
  localparam int unsigned PORT_IDX_W     = $clog2(NUM_IN_DEF);
  localparam int unsigned CREDIT_CNT_W   = $clog2(CREDIT_NUM_DEF + 1);

  typedef logic [QOS_W-1:0]        qos_t;
  typedef logic [PORT_IDX_W-1:0]   port_idx_t;
  typedef logic [CREDIT_CNT_W-1:0] credit_cnt_t;

  // Decoded head-flit header; qos_value shares qos_t with the arbiter request path.
  typedef struct packed {
    port_idx_t  dest_port;
    qos_t       qos_value;
    logic [1:0] flit_type;
  } flit_hdr_t;

endpackage

// File: rtl/output_port_qos_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search; returns the first requester at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic             found_o
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_hi_pick;
  logic [N-1:0] w_lo_pick;

  // Requesters at index >= ptr take precedence; otherwise wrap to the lowest requester.
  assign w_mask    = ~((N'(1) << ptr_i) - N'(1));
  assign w_hi      = req_i & w_mask;
  assign w_hi_pick = w_hi & (~w_hi + N'(1));
  assign w_lo_pick = req_i & (~req_i + N'(1));

  assign pick_o  = (|w_hi) ? w_hi_pick : w_lo_pick;
  assign found_o = |req_i;

endmodule

// File: rtl/output_port_qos_arbiter.sv
// Per-output-port QoS switch arbiter with round-robin tie-break and downstream credit tracking.
// Define QOS_AGING_EN to add per-input starvation aging (urgent tier overrides QoS).
module output_port_qos_arbiter #(
  parameter int unsigned NUM_IN     = noc_arb_pkg::NUM_IN_DEF,
  parameter int unsigned QOS_W      = noc_arb_pkg::QOS_W,
  parameter int unsigned CREDIT_NUM = noc_arb_pkg::CREDIT_NUM_DEF,
  parameter int unsigned AGE_THRESH = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_IN-1:0]                  req_v_i,
  input  logic [NUM_IN*QOS_W-1:0]            req_qos_i,
  input  logic                               credit_ret_i,
  output logic [NUM_IN-1:0]                  gnt_o,
  output logic                               gnt_v_o,
  output logic [$clog2(NUM_IN)-1:0]          gnt_idx_o,
  output logic [$clog2(CREDIT_NUM+1)-1:0]    credit_cnt_o,
  output logic                               credit_err_o
);
  import noc_arb_pkg::*;

  localparam int unsigned PTR_W = $clog2(NUM_IN);
  localparam int unsigned CNT_W = $clog2(CREDIT_NUM + 1);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0]  r_credit_cnt;
  logic              r_credit_err;

  logic [QOS_W-1:0]  w_qos_max;
  logic [NUM_IN-1:0] w_top_mask;
  logic [NUM_IN-1:0] w_qos_pick;
  logic              w_qos_found;
  logic [NUM_IN-1:0] w_sel;
  logic              w_credit_ok;
  logic [NUM_IN-1:0] w_gnt;
  logic              w_gnt_v;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [PTR_W-1:0]  w_rr_next;

  // Highest QoS among valid requesters; invalid inputs' qos is ignored.
  always_comb begin
    w_qos_max = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (req_v_i[i] && (req_qos_i[i*QOS_W +: QOS_W] > w_qos_max)) begin
        w_qos_max = req_qos_i[i*QOS_W +: QOS_W];
      end
    end
  end

  always_comb begin
    w_top_mask = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_top_mask[i] = req_v_i[i] && (req_qos_i[i*QOS_W +: QOS_W] == w_qos_max);
    end
  end

  rr_pick #(.N(NUM_IN), .PTR_W(PTR_W)) u_qos_pick (
    .req_i   (w_top_mask),
    .ptr_i   (r_rr_ptr),
    .pick_o  (w_qos_pick),
    .found_o (w_qos_found)
  );

  assign w_credit_ok = (r_credit_cnt != '0);

`ifdef QOS_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_THRESH + 1);

  logic [AGE_W-1:0]  r_age [NUM_IN];
  logic [NUM_IN-1:0] w_urgent;
  logic [NUM_IN-1:0] w_urg_pick;
  logic              w_urg_found;

  always_comb begin
    w_urgent = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_urgent[i] = req_v_i[i] && (r_age[i] >= AGE_W'(AGE_THRESH));
    end
  end

  rr_pick #(.N(NUM_IN), .PTR_W(PTR_W)) u_urg_pick (
    .req_i   (w_urgent),
    .ptr_i   (r_rr_ptr),
    .pick_o  (w_urg_pick),
    .found_o (w_urg_found)
  );

  assign w_sel = w_urg_found ? w_urg_pick : w_qos_pick;

  // Age saturates; cleared on grant or idle, frozen while no credit is available.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!req_v_i[i] || w_gnt[i]) begin
          r_age[i] <= '0;
        end else if (w_credit_ok && (r_age[i] != '1)) begin
          r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end
`else
  logic w_unused_age;

  assign w_unused_age = (AGE_THRESH != 0);
  assign w_sel        = w_qos_pick;
`endif

  assign w_gnt   = (w_credit_ok && !rst && w_qos_found) ? w_sel : '0;
  assign w_gnt_v = |w_gnt;

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gnt[i]) w_gnt_idx = w_gnt_idx | PTR_W'(i);
    end
  end

  assign w_rr_next = (w_gnt_idx == PTR_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

  // Pointer advance past the winner and credit bookkeeping; overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_credit_cnt <= CNT_W'(CREDIT_NUM);
      r_credit_err <= 1'b0;
    end else begin
      if (w_gnt_v) r_rr_ptr <= w_rr_next;
      case ({w_gnt_v, credit_ret_i})
        2'b10:   r_credit_cnt <= r_credit_cnt - CNT_W'(1);
        2'b01: begin
          if (r_credit_cnt == CNT_W'(CREDIT_NUM)) r_credit_err <= 1'b1;
          else                                    r_credit_cnt <= r_credit_cnt + CNT_W'(1);
        end
        default: r_credit_cnt <= r_credit_cnt;
      endcase
    end
  end

  assign gnt_o        = w_gnt;
  assign gnt_v_o      = w_gnt_v;
  assign gnt_idx_o    = w_gnt_idx;
  assign credit_cnt_o = r_credit_cnt;
  assign credit_err_o = r_credit_err;

endmodule

// File: tb/tb_output_port_qos_arbiter.sv
// Directed self-checking bench for output_port_qos_arbiter; the aging scenario runs when QOS_AGING_EN is defined.
module tb_output_port_qos_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  req_v;
  logic [19:0] req_qos;
  logic        credit_ret;
  logic [4:0]  gnt;
  logic        gnt_v;
  logic [2:0]  gnt_idx;
  logic [2:0]  credit_cnt;
  logic        credit_err;

  int n_vec;
  int n_err;

  output_port_qos_arbiter #(
    .NUM_IN(5), .QOS_W(4), .CREDIT_NUM(4), .AGE_THRESH(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_v_i      (req_v),
    .req_qos_i    (req_qos),
    .credit_ret_i (credit_ret),
    .gnt_o        (gnt),
    .gnt_v_o      (gnt_v),
    .gnt_idx_o    (gnt_idx),
    .credit_cnt_o (credit_cnt),
    .credit_err_o (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_qos(input int i, input logic [3:0] q);
    req_qos[i*4 +: 4] = q;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_v = '0; req_qos = '0; credit_ret = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_v = 5'b11111; req_qos = {5{4'd3}}; credit_ret = 1'b0;
    #1;
    n_vec++;
    if (gnt !== 5'b0) begin
      n_err++; $display("FAIL rst_forces_gnt: got %b want 00000", gnt);
    end
    @(negedge clk);
    rst = 1'b0; req_v = '0;
    #1;
    n_vec++;
    if (gnt !== 5'b0 || gnt_v !== 1'b0 || gnt_idx !== 3'd0) begin
      n_err++; $display("FAIL reset_gnt: got gnt=%b v=%b idx=%0d want 0/0/0", gnt, gnt_v, gnt_idx);
    end
    n_vec++;
    if (credit_cnt !== 3'd4) begin
      n_err++; $display("FAIL reset_credit: got %0d want 4", credit_cnt);
    end
    n_vec++;
    if (credit_err !== 1'b0) begin
      n_err++; $display("FAIL reset_err: got %b want 0", credit_err);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_v = 5'b11111; req_qos = {5{4'd3}}; credit_ret = 1'b1;
      #1;
      n_vec++;
      if (gnt !== (5'b1 << exp_seq[c]) || gnt_idx !== 3'(exp_seq[c]) || gnt_v !== 1'b1) begin
        n_err++;
        $display("FAIL rr_cycle%0d: got gnt=%b idx=%0d want idx=%0d", c, gnt, gnt_idx, exp_seq[c]);
      end
      n_vec++;
      if (credit_cnt !== 3'd4) begin
        n_err++; $display("FAIL rr_credit%0d: got %0d want 4", c, credit_cnt);
      end
    end
  endtask

  task automatic test_qos_priority_and_credit_block();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_v = 5'b01010; req_qos = '0; set_qos(1, 4'd2); set_qos(3, 4'd7); credit_ret = 1'b0;
      #1;
      n_vec++;
      if (gnt !== 5'b01000 || gnt_idx !== 3'd3 || credit_cnt !== 3'(4 - c)) begin
        n_err++;
        $display("FAIL qos_b2b%0d: got gnt=%b idx=%0d cnt=%0d want 01000/3/%0d", c, gnt, gnt_idx, credit_cnt, 4 - c);
      end
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (gnt !== 5'b0 || gnt_v !== 1'b0 || gnt_idx !== 3'd0 || credit_cnt !== 3'd0) begin
      n_err++; $display("FAIL qos_no_credit: got gnt=%b v=%b idx=%0d cnt=%0d want 0/0/0/0", gnt, gnt_v, gnt_idx, credit_cnt);
    end
    // Returned credit is not usable in the cycle it arrives.
    @(negedge clk);
    credit_ret = 1'b1;
    #1;
    n_vec++;
    if (gnt !== 5'b0) begin
      n_err++; $display("FAIL credit_ret_same_cycle: got %b want 00000", gnt);
    end
    @(negedge clk);
    credit_ret = 1'b0;
    #1;
    n_vec++;
    if (gnt !== 5'b01000 || credit_cnt !== 3'd1) begin
      n_err++; $display("FAIL credit_ret_next_cycle: got gnt=%b cnt=%0d want 01000/1", gnt, credit_cnt);
    end
    @(negedge clk);
    req_v = '0;
    #1;
    n_vec++;
    if (credit_cnt !== 3'd0) begin
      n_err++; $display("FAIL credit_after_regrant: got %0d want 0", credit_cnt);
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    @(negedge clk);
    req_v = 5'b01000; req_qos = '0; set_qos(3, 4'd5); credit_ret = 1'b1;
    #1;
    n_vec++;
    if (gnt !== 5'b01000) begin
      n_err++; $display("FAIL wrap_setup: got %b want 01000", gnt);
    end
    // Invalid input 1 carries qos 15 that must be ignored; ptr=4 so ties at qos 5 wrap to 0.
    @(negedge clk);
    req_v = 5'b10101; req_qos = '0; set_qos(0, 4'd5); set_qos(1, 4'd15); set_qos(2, 4'd5); set_qos(4, 4'd4);
    #1;
    n_vec++;
    if (gnt !== 5'b00001 || gnt_idx !== 3'd0) begin
      n_err++; $display("FAIL wrap_pick0: got gnt=%b idx=%0d want 00001/0", gnt, gnt_idx);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (gnt !== 5'b00100 || gnt_idx !== 3'd2) begin
      n_err++; $display("FAIL wrap_pick2: got gnt=%b idx=%0d want 00100/2", gnt, gnt_idx);
    end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    @(negedge clk);
    req_v = '0; credit_ret = 1'b1;
    #1;
    n_vec++;
    if (credit_err !== 1'b0 || credit_cnt !== 3'd4) begin
      n_err++; $display("FAIL ovf_before: got err=%b cnt=%0d want 0/4", credit_err, credit_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      credit_ret = 1'b0;
      #1;
      n_vec++;
      if (credit_err !== 1'b1 || credit_cnt !== 3'd4) begin
        n_err++; $display("FAIL ovf_sticky%0d: got err=%b cnt=%0d want 1/4", c, credit_err, credit_cnt);
      end
    end
    @(negedge clk);
    req_v = 5'b00001; req_qos = '0; set_qos(0, 4'd1); credit_ret = 1'b1;
    #1;
    n_vec++;
    if (gnt !== 5'b00001) begin
      n_err++; $display("FAIL ovf_grant_ret: got %b want 00001", gnt);
    end
    @(negedge clk);
    req_v = '0; credit_ret = 1'b0;
    #1;
    n_vec++;
    if (credit_cnt !== 3'd4 || credit_err !== 1'b1) begin
      n_err++; $display("FAIL grant_ret_hold: got cnt=%0d err=%b want 4/1", credit_cnt, credit_err);
    end
    do_reset();
    #1;
    n_vec++;
    if (credit_err !== 1'b0) begin
      n_err++; $display("FAIL ovf_cleared: got %b want 0", credit_err);
    end
  endtask

`ifdef QOS_AGING_EN
  task automatic test_aging();
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      req_v = 5'b00101; req_qos = '0; set_qos(0, 4'd0); set_qos(2, 4'd15); credit_ret = 1'b1;
      #1;
      n_vec++;
      if (gnt !== ((c == 16) ? 5'b00001 : 5'b00100)) begin
        n_err++; $display("FAIL aging_cycle%0d: got %b want %b", c, gnt, (c == 16) ? 5'b00001 : 5'b00100);
      end
    end
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; req_v = '0; req_qos = '0; credit_ret = 1'b0;
    test_reset();
    test_round_robin();
    test_qos_priority_and_credit_block();
    test_rr_wrap();
    test_credit_overflow();
`ifdef QOS_AGING_EN
    test_aging();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
